mul_share_arb: RTL and testbench

Round-robin arbiter and scheduler that shares one pipelined 10x18 unsigned multiplier (fixed latency, no backpressure) among NREQ parameter-computation requesters in the Algorithm/parameter datapath. It accepts at most one operand pair per cycle and drives registered operands to the multiplier. It tracks each issued operation's requester ID through a tag pipeline aligned to the multiplier latency, and returns each product tagged with its requester ID. Requesters must be able to accept responses unconditionally.

---
 rtl/mul_share_arb.sv | 127 ++++++++++++
 tb/tb_mul_share_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// Purpose: round-robin share of one pipelined 10x18 unsigned multiplier among NREQ requesters.
// Latency: accept in cycle k -> operands on mul_a/mul_b in k+1 -> tagged product in k+1+MUL_LAT.
// Backpressure: none; one grant per cycle, responses must be taken unconditionally.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_mask, req_valid  per-requester enable / operand-pair valid
//   req_a, req_b         packed operands, requester i at [10i+9:10i] / [18i+17:18i]
//   req_ready            one-hot-or-zero combinational grant
//   mul_a, mul_b         registered operands to the external multiplier
//   mul_result           product from the external multiplier
//   rsp_valid/id/data    tagged product, one per cycle at most
//   busy, inflight       occupancy of the tag pipeline
module mul_share_arb #(
   parameter  int NREQ    = 4,
   parameter  int MUL_LAT = 4,
   localparam int IDW     = $clog2(NREQ),
   localparam int INFW    = $clog2(MUL_LAT + 2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      cfg_mask,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*10-1:0]   req_a,
   input  logic [NREQ*18-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [9:0]           mul_a,
   output logic [17:0]          mul_b,
   input  logic [27:0]          mul_result,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [27:0]          rsp_data,
   output logic                 busy,
   output logic [INFW-1:0]      inflight
);

   logic [NREQ-1:0]             elig;
   logic                        gnt_vld;
   logic [IDW-1:0]              gnt_id;
   logic [IDW:0]                rot_sum;
   logic [IDW-1:0]              rot_idx;

   logic [IDW-1:0]              ptr_q, ptr_d;
   logic [9:0]                  mul_a_q, mul_a_d;
   logic [17:0]                 mul_b_q, mul_b_d;
   logic [MUL_LAT:0]            tag_vld_q, tag_vld_d;
   logic [MUL_LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
   logic [INFW-1:0]             vld_cnt;

   // Scan requesters starting at the pointer; the extra bit of rot_sum
   // lets the wrap be done with a compare-and-subtract for any NREQ.
   always_comb begin
      elig    = req_valid & cfg_mask;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      rot_sum = '0;
      rot_idx = '0;
      for (int off = 0; off < NREQ; off++) begin
         rot_sum = {1'b0, ptr_q} + (IDW+1)'(off);
         if (rot_sum >= (IDW+1)'(NREQ)) begin
            rot_sum = rot_sum - (IDW+1)'(NREQ);
         end
         rot_idx = rot_sum[IDW-1:0];
         if (!gnt_vld && elig[rot_idx]) begin
            gnt_vld = 1'b1;
            gnt_id  = rot_idx;
         end
      end
   end

   // Grant is suppressed during reset so nothing looks accepted while
   // the state is being cleared.
   always_comb begin
      req_ready = '0;
      if (gnt_vld && rst_n) begin
         req_ready[gnt_id] = 1'b1;
      end
   end

   always_comb begin
      ptr_d   = ptr_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      if (gnt_vld) begin
         mul_a_d = req_a[int'(gnt_id)*10 +: 10];
         mul_b_d = req_b[int'(gnt_id)*18 +: 18];
         ptr_d   = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
      end
      // Tag pipeline is one stage longer than the multiplier because the
      // operand register adds a cycle in front of it.
      tag_vld_d = {tag_vld_q[MUL_LAT-1:0], gnt_vld};
      tag_id_d  = {tag_id_q[MUL_LAT-1:0], gnt_id};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         ptr_q     <= ptr_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

   always_comb begin
      vld_cnt = '0;
      for (int i = 0; i <= MUL_LAT; i++) begin
         vld_cnt = vld_cnt + INFW'(tag_vld_q[i]);
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   // Stale multiplier contents never leak out: validity comes only from tags.
   assign rsp_valid = tag_vld_q[MUL_LAT];
   assign rsp_id    = tag_id_q[MUL_LAT];
   assign rsp_data  = mul_result;
   assign inflight  = vld_cnt;
   assign busy      = (vld_cnt != '0);

endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;

   localparam int NREQ    = 4;
   localparam int MUL_LAT = 4;
   localparam int IDW     = $clog2(NREQ);
   localparam int INFW    = $clog2(MUL_LAT + 2);

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      cfg_mask;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*10-1:0]   req_a;
   logic [NREQ*18-1:0]   req_b;
   logic [NREQ-1:0]      req_ready;
   logic [9:0]           mul_a;
   logic [17:0]          mul_b;
   logic [27:0]          mul_result;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [27:0]          rsp_data;
   logic                 busy;
   logic [INFW-1:0]      inflight;

   mul_share_arb #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_mask   (cfg_mask),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .busy       (busy),
      .inflight   (inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: MUL_LAT register stages, not reset.
   logic [27:0] mp [MUL_LAT];
   always @(posedge clk) begin
      mp[0] <= 28'(mul_a) * 28'(mul_b);
      for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
   end
   assign mul_result = mp[MUL_LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      logic [27:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   int n_total = 0;
   int n_pass  = 0;

   // Reference state: rotating start position and last accepted operands.
   int          model_ptr = 0;
   logic [9:0]  exp_a = '0;
   logic [17:0] exp_b = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
   endtask

   function automatic int model_grant(input logic [NREQ-1:0] el);
      for (int off = 0; off < NREQ; off++) begin
         if (el[(model_ptr + off) % NREQ]) return (model_ptr + off) % NREQ;
      end
      return -1;
   endfunction

   task automatic set_ops(input int i, input int a, input int b);
      req_a[i*10 +: 10] = 10'(a);
      req_b[i*18 +: 18] = 18'(b);
   endtask

   // One cycle: inputs already applied; decide the expected grant away from
   // the edge, record the expected response, then step past the edge.
   task automatic tick();
      logic [NREQ-1:0] er;
      int              g;
      exp_t            e;
      @(negedge clk);
      g  = model_grant(req_valid & cfg_mask);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      if (g >= 0) begin
         exp_a     = req_a[g*10 +: 10];
         exp_b     = req_b[g*18 +: 18];
         e.id      = g;
         e.data    = 28'(exp_a) * 28'(exp_b);
         e.due     = cyc + 1 + MUL_LAT;
         sb.push_back(e);
         model_ptr = (g + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      chk("mul_a", 64'(mul_a), 64'(exp_a));
      chk("mul_b", 64'(mul_b), 64'(exp_b));
   endtask

   task automatic idle(input int n);
      req_valid = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard.
   initial begin
      exp_t e;
      logic ev;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n) begin
            chk("inflight", 64'(inflight), 64'(sb.size()));
            chk("busy", 64'(busy), 64'(sb.size() != 0));
            ev = (sb.size() > 0) && (sb[0].due == cyc);
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (ev) begin
               e = sb.pop_front();
               chk("rsp_id", 64'(rsp_id), 64'(e.id));
               chk("rsp_data", 64'(rsp_data), 64'(e.data));
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      cfg_mask  = '1;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      #3;
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_inflight", 64'(inflight), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single op, largest operands.
      set_ops(0, 1023, 262143);
      req_valid = 4'b0001;
      tick();
      idle(8);

      // All requesters back-to-back.
      for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, 100);
      req_valid = '1;
      for (int i = 0; i < 12; i++) tick();
      idle(7);

      // Mask out requesters 0 and 2.
      cfg_mask = 4'b1010;
      req_valid = '1;
      for (int i = 0; i < 8; i++) tick();
      cfg_mask = '1;
      idle(7);

      // Pointer rotation: grant 2, then 0 and 3 compete.
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b1001;
      tick();
      tick();
      idle(7);

      // Async reset with three operations in flight.
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 1023), $urandom_range(0, 262143));
      req_valid = '1;
      tick();
      tick();
      tick();
      req_valid = '0;
      tick();
      #2;
      rst_n     = 1'b0;
      req_valid = '1;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_inflight", 64'(inflight), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      chk("midrst_mul_a", 64'(mul_a), 64'd0);
      sb.delete();
      model_ptr = 0;
      exp_a     = '0;
      exp_b     = '0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      idle(8);

      // Zero operand with idle gaps.
      set_ops(1, 0, 262143);
      for (int r = 0; r < 3; r++) begin
         req_valid = 4'b0010;
         tick();
         idle(2);
      end
      idle(6);

      // Randomized traffic with occasional mask changes.
      for (int t = 0; t < 400; t++) begin
         if (t % 25 == 0) cfg_mask = 4'($urandom_range(0, 15));
         if (t % 100 == 0) cfg_mask = '1;
         req_valid = 4'($urandom);
         for (int i = 0; i < NREQ; i++) set_ops(i, $urandom_range(0, 1023), $urandom_range(0, 262143));
         tick();
      end
      cfg_mask = '1;
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
